// File: rtl/hmem_backing_store.sv
// Byte-addressable main-memory model behind the L2 with a fixed access latency.
// Define HMEM_RANGE_CHECK_EN to flag out-of-range requests with req_error instead of wrapping.
module hmem_backing_store #(
    parameter int unsigned            XLEN      = 32,
    parameter int unsigned            MEM_BYTES = 65536,
    parameter logic [XLEN-1:0]        BASE_ADDR = '0,
    parameter int unsigned            LATENCY   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_operation,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_address,
    input  logic [XLEN-1:0] req_store_word,
    output logic            req_fulfilled,
    output logic [XLEN-1:0] req_loaded_word,
    output logic            req_error
);

    // state   | meaning
    // IDLE    | waiting for req_valid; fields latched on acceptance
    // WAIT    | latency countdown
    // RESPOND | one-cycle completion; store commits on this edge
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    localparam int unsigned AW = $clog2(MEM_BYTES);

`ifdef HMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic              r_op;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_offset;
    logic [XLEN-1:0]   r_wdata;
    logic [7:0]        r_mem [MEM_BYTES];

    logic [AW-1:0]     w_idx;
    logic [XLEN-1:0]   w_rd_word;
    logic [XLEN-1:0]   w_load_data;
    logic              w_err;
    logic              w_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_size   <= '0;
            r_offset <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && req_valid) begin
                r_cnt    <= 8'(LATENCY - 1);
                r_op     <= req_operation;
                r_size   <= req_size;
                r_offset <= req_address - BASE_ADDR;
                r_wdata  <= req_store_word;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (req_valid) w_state_nxt = (LATENCY == 1) ? S_RESPOND : S_WAIT;
            S_WAIT:    if (r_cnt <= 8'd1) w_state_nxt = S_RESPOND;
            S_RESPOND: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Size 3 falls into the word case everywhere: bit 1 set means word.
    always_comb begin
        w_idx = r_offset[AW-1:0];
        if (r_size == 2'd1)
            w_idx[0] = 1'b0;
        else if (r_size[1])
            w_idx[1:0] = 2'b00;
    end

    assign w_rd_word = {r_mem[w_idx + AW'(3)], r_mem[w_idx + AW'(2)],
                        r_mem[w_idx + AW'(1)], r_mem[w_idx]};

    always_comb begin
        w_load_data = w_rd_word;
        if (r_size == 2'd0)
            w_load_data = {{(XLEN-8){1'b0}}, w_rd_word[7:0]};
        else if (r_size == 2'd1)
            w_load_data = {{(XLEN-16){1'b0}}, w_rd_word[15:0]};
    end

    assign w_err = RANGE_CHECK && (r_offset >= XLEN'(MEM_BYTES));
    assign w_we  = (r_state == S_RESPOND) && r_op && !w_err;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= r_wdata[7:0];
            if (r_size != 2'd0)
                r_mem[w_idx + AW'(1)] <= r_wdata[15:8];
            if (r_size[1]) begin
                r_mem[w_idx + AW'(2)] <= r_wdata[23:16];
                r_mem[w_idx + AW'(3)] <= r_wdata[31:24];
            end
        end
    end

    always_comb begin
        req_fulfilled   = 1'b0;
        req_loaded_word = '0;
        req_error       = 1'b0;
        if (r_state == S_RESPOND) begin
            req_fulfilled = 1'b1;
            req_error     = w_err;
            if (!r_op)
                req_loaded_word = w_err ? XLEN'(32'hDEAD_BEEF) : w_load_data;
        end
    end

endmodule

// File: tb/tb_hmem_backing_store.sv
// Directed bench for hmem_backing_store: latency, lanes, alignment, abort, back-to-back, range.
module tb_hmem_backing_store;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_operation = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_address = '0;
    logic [31:0] req_store_word = '0;
    logic        req_fulfilled;
    logic [31:0] req_loaded_word;
    logic        req_error;

    int n_total = 0;
    int n_bad   = 0;
    int n_pulse = 0;
    int p0;

    logic [31:0] g_d, g_post_d;
    logic        g_e, g_post_f;
    int          g_n;

    hmem_backing_store #(
        .XLEN(32), .MEM_BYTES(65536), .BASE_ADDR(32'h0), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_operation(req_operation), .req_size(req_size),
        .req_address(req_address), .req_store_word(req_store_word),
        .req_fulfilled(req_fulfilled), .req_loaded_word(req_loaded_word),
        .req_error(req_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (req_fulfilled === 1'b1) n_pulse++;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ful(output int n, output logic [31:0] d, output logic e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (req_fulfilled !== 1'b1 && n < 40);
        d = req_loaded_word;
        e = req_error;
    endtask

    task automatic drive(input logic op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
        req_operation  = op;
        req_size       = sz;
        req_address    = a;
        req_store_word = w;
        req_valid      = 1'b1;
    endtask

    task automatic xact(input logic op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
        drive(op, sz, a, w);
        wait_ful(g_n, g_d, g_e);
        req_valid = 1'b0;
        @(posedge clk); #1;
        g_post_f = req_fulfilled;
        g_post_d = req_loaded_word;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        chk_val("rst_fulfilled", 32'(req_fulfilled), 32'd0);
        chk_val("rst_loaded", req_loaded_word, 32'd0);
        chk_val("rst_error", 32'(req_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        xact(1'b1, 2'd2, 32'h100, 32'h1111_2222);
        chk_val("lat_st100", g_n, LAT);
        chk_val("st_loaded_zero", g_d, 32'd0);

        // store aborted by reset while counting down
        p0 = n_pulse;
        drive(1'b1, 2'd2, 32'h100, 32'h1234_5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        req_valid = 1'b0;
        chk_val("abort_fulfilled", 32'(req_fulfilled), 32'd0);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk_val("abort_no_pulse", n_pulse, p0);

        xact(1'b0, 2'd2, 32'h100, 32'h0);
        chk_val("ld100_after_abort", g_d, 32'h1111_2222);
        chk_val("lat_ld100", g_n, LAT);

        xact(1'b1, 2'd2, 32'h40, 32'hCAFE_F00D);
        chk_val("lat_st40", g_n, LAT);
        chk_val("st40_single_pulse", 32'(g_post_f), 32'd0);

        xact(1'b0, 2'd2, 32'h40, 32'h0);
        chk_val("ld40_word", g_d, 32'hCAFE_F00D);
        chk_val("ld40_err", 32'(g_e), 32'd0);
        chk_val("ld40_data_clears", g_post_d, 32'd0);

        xact(1'b1, 2'd0, 32'h41, 32'h1234_56AA);
        xact(1'b0, 2'd2, 32'h40, 32'h0);
        chk_val("ld40_after_byte", g_d, 32'hCAFE_AA0D);
        xact(1'b0, 2'd1, 32'h42, 32'h0);
        chk_val("ld42_half", g_d, 32'h0000_CAFE);
        xact(1'b0, 2'd0, 32'h43, 32'h0);
        chk_val("ld43_byte", g_d, 32'h0000_00CA);
        xact(1'b0, 2'd2, 32'h43, 32'h0);
        chk_val("ld43_word_misal", g_d, 32'hCAFE_AA0D);
        xact(1'b0, 2'd1, 32'h41, 32'h0);
        chk_val("ld41_half_misal", g_d, 32'h0000_AA0D);
        xact(1'b0, 2'd3, 32'h40, 32'h0);
        chk_val("ld40_size3", g_d, 32'hCAFE_AA0D);

        xact(1'b1, 2'd2, 32'h44, 32'h0);
        xact(1'b1, 2'd1, 32'h47, 32'h5555_BEEF);
        xact(1'b0, 2'd2, 32'h44, 32'h0);
        chk_val("ld44_after_half", g_d, 32'hBEEF_0000);

        // inputs changed after acceptance must be ignored
        drive(1'b0, 2'd2, 32'h40, 32'h0);
        @(posedge clk); #1;
        req_address    = 32'h100;
        req_operation  = 1'b1;
        req_store_word = 32'hFFFF_FFFF;
        wait_ful(g_n, g_d, g_e);
        chk_val("latched_lat", g_n + 1, LAT);
        chk_val("latched_data", g_d, 32'hCAFE_AA0D);
        req_valid = 1'b0;
        @(posedge clk); #1;

        // back-to-back with valid held, fields swapped the cycle after the pulse
        drive(1'b0, 2'd2, 32'h40, 32'h0);
        wait_ful(g_n, g_d, g_e);
        chk_val("b2b_first", g_d, 32'hCAFE_AA0D);
        @(posedge clk); #1;
        chk_val("b2b_gap_low", 32'(req_fulfilled), 32'd0);
        req_address = 32'h100;
        wait_ful(g_n, g_d, g_e);
        chk_val("b2b_spacing", g_n + 1, LAT + 1);
        chk_val("b2b_second", g_d, 32'h1111_2222);
        req_valid = 1'b0;
        @(posedge clk); #1;

        xact(1'b1, 2'd2, 32'h0, 32'hA5A5_5A5A);
        xact(1'b0, 2'd2, 32'h1_0000, 32'h0);
`ifdef HMEM_RANGE_CHECK_EN
        chk_val("oob_ld_data", g_d, 32'hDEAD_BEEF);
        chk_val("oob_ld_err", 32'(g_e), 32'd1);
`else
        chk_val("wrap_ld_data", g_d, 32'hA5A5_5A5A);
        chk_val("wrap_ld_err", 32'(g_e), 32'd0);
`endif
        chk_val("oob_ld_lat", g_n, LAT);
        xact(1'b1, 2'd2, 32'h1_0000, 32'h0BAD_0BAD);
        xact(1'b0, 2'd2, 32'h0, 32'h0);
`ifdef HMEM_RANGE_CHECK_EN
        chk_val("oob_st_suppressed", g_d, 32'hA5A5_5A5A);
`else
        chk_val("wrap_st_lands", g_d, 32'h0BAD_0BAD);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
